// File: rtl/tx_packet_scheduler.sv
// tx_packet_scheduler
// Packet-level sequencer for the 2-bit RMII transmit serializer. For each packet it
// chooses between one video line (LINE_PIXELS bytes from the frame BRAM) and one audio
// chunk (AUDIO_CHUNK bytes from the audio FIFO). It offers a single command, waits for
// the packet to complete, then holds off for the inter-frame gap. A frame of NUM_LINES
// lines is streamed repeatedly, and a line whose packet is aborted is sent again.
//
// Optional feature: define TX_WATCHDOG_EN to enable the WAIT_DONE watchdog. A packet
// that stays in WAIT_DONE for TIMEOUT_CYCLES cycles is then handled as aborted, and the
// sticky err_timeout flag is raised. Without the macro, err_timeout is tied to 0.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   enable              stream enable (level)
//   audio_level         bytes currently held in the audio FIFO
//   cmd_valid/ready     command handshake towards the serializer
//   cmd_type            0 = video, 1 = audio
//   cmd_addr, cmd_len   first pixel address (0 for audio) and payload byte count
//   tx_done, tx_abort   completion / abort pulses from the serializer
//   frame_start         pulses when a line-0 video command is accepted
//   line_idx            line of the next or current video packet
//   sched_busy          high in every state except IDLE
//   err_timeout         sticky watchdog flag
module tx_packet_scheduler #(
    parameter int unsigned LINE_PIXELS    = 320,
    parameter int unsigned NUM_LINES      = 240,
    parameter int unsigned AUDIO_CHUNK    = 64,
    parameter int unsigned IFG_CYCLES     = 48,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [9:0]  audio_level,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        cmd_type,
    output logic [16:0] cmd_addr,
    output logic [8:0]  cmd_len,
    input  logic        tx_done,
    input  logic        tx_abort,
    output logic        frame_start,
    output logic [7:0]  line_idx,
    output logic        sched_busy,
    output logic        err_timeout
);

    localparam int unsigned GapW = $clog2(IFG_CYCLES + 1);

    typedef enum logic [2:0] {StIdle, StDecide, StIssue, StWaitDone, StGap} state_e;

    state_e          state_q, state_d;
    logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
    logic            cmd_valid_q, cmd_valid_d;
    logic            cmd_type_q, cmd_type_d;
    logic [16:0]     cmd_addr_q, cmd_addr_d;
    logic [8:0]      cmd_len_q, cmd_len_d;
    logic            frame_start_q, frame_start_d;
    logic [7:0]      line_idx_q, line_idx_d;
    logic            last_audio_q, last_audio_d;

    logic        audio_ok;
    logic        sel_audio;
    logic        handshake;
    logic        timeout;
    logic [16:0] line_addr;

    assign audio_ok  = audio_level >= 10'(AUDIO_CHUNK);
    // Audio wins when it was not sent last, or when video is disabled (pending audio drains).
    assign sel_audio = audio_ok && (!last_audio_q || !enable);
    assign handshake = cmd_valid_q && cmd_ready;
    assign line_addr = 17'(line_idx_q) * 17'(LINE_PIXELS);

`ifdef TX_WATCHDOG_EN
    localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WdW-1:0] wd_cnt_q, wd_cnt_d;
    logic           err_q, err_d;

    // A real completion in the same cycle takes precedence over the watchdog.
    assign timeout = (state_q == StWaitDone) && !tx_done && !tx_abort &&
                     (wd_cnt_q == WdW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        err_d    = err_q | timeout;
        if (state_q == StIssue && handshake) begin
            wd_cnt_d = '0;
        end else if (state_q == StWaitDone) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            err_q    <= err_d;
        end
    end

    assign err_timeout = err_q;
`else
    assign timeout     = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (enable) state_d = StDecide;
            StDecide:   state_d = (audio_ok || enable) ? StIssue : StIdle;
            StIssue:    if (handshake) state_d = StWaitDone;
            StWaitDone: if (tx_done || tx_abort || timeout) state_d = StGap;
            StGap:      if (gap_cnt_q == GapW'(IFG_CYCLES - 1)) state_d = StDecide;
            default:    state_d = StIdle;
        endcase
    end

    // Output / datapath next-state logic
    always_comb begin
        gap_cnt_d     = gap_cnt_q;
        cmd_valid_d   = cmd_valid_q;
        cmd_type_d    = cmd_type_q;
        cmd_addr_d    = cmd_addr_q;
        cmd_len_d     = cmd_len_q;
        frame_start_d = 1'b0;
        line_idx_d    = line_idx_q;
        last_audio_d  = last_audio_q;
        unique case (state_q)
            StDecide: begin
                if (audio_ok || enable) begin
                    cmd_valid_d = 1'b1;
                    cmd_type_d  = sel_audio;
                    cmd_addr_d  = sel_audio ? 17'd0 : line_addr;
                    cmd_len_d   = sel_audio ? 9'(AUDIO_CHUNK) : 9'(LINE_PIXELS);
                end
            end
            StIssue: begin
                if (handshake) begin
                    cmd_valid_d   = 1'b0;
                    last_audio_d  = cmd_type_q;
                    frame_start_d = !cmd_type_q && (line_idx_q == 8'd0);
                end
            end
            StWaitDone: begin
                // tx_done wins over tx_abort; an abort leaves line_idx for a resend.
                if (tx_done && !cmd_type_q) begin
                    line_idx_d = (line_idx_q == 8'(NUM_LINES - 1)) ? 8'd0 : line_idx_q + 8'd1;
                end
                gap_cnt_d = '0;
            end
            StGap: gap_cnt_d = gap_cnt_q + 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gap_cnt_q     <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_type_q    <= 1'b0;
            cmd_addr_q    <= '0;
            cmd_len_q     <= '0;
            frame_start_q <= 1'b0;
            line_idx_q    <= '0;
            last_audio_q  <= 1'b0;
        end else begin
            gap_cnt_q     <= gap_cnt_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_type_q    <= cmd_type_d;
            cmd_addr_q    <= cmd_addr_d;
            cmd_len_q     <= cmd_len_d;
            frame_start_q <= frame_start_d;
            line_idx_q    <= line_idx_d;
            last_audio_q  <= last_audio_d;
        end
    end

    assign cmd_valid   = cmd_valid_q;
    assign cmd_type    = cmd_type_q;
    assign cmd_addr    = cmd_addr_q;
    assign cmd_len     = cmd_len_q;
    assign frame_start = frame_start_q;
    assign line_idx    = line_idx_q;
    assign sched_busy  = (state_q != StIdle);

endmodule

// File: tb/tb_tx_packet_scheduler.sv
// Self-checking bench for tx_packet_scheduler (default build, watchdog disabled).
// Expected commands are pushed to a scoreboard as each packet is set up and popped
// when the DUT presents cmd_valid.
module tb_tx_packet_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [9:0]  audio_level;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_type;
    logic [16:0] cmd_addr;
    logic [8:0]  cmd_len;
    logic        tx_done;
    logic        tx_abort;
    logic        frame_start;
    logic [7:0]  line_idx;
    logic        sched_busy;
    logic        err_timeout;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        typ;
        logic [16:0] addr;
        logic [8:0]  len;
        logic        fs;
    } cmd_t;

    cmd_t exp_q[$];
    logic exp_fs;

    tx_packet_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .audio_level(audio_level),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_type   (cmd_type),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .tx_done    (tx_done),
        .tx_abort   (tx_abort),
        .frame_start(frame_start),
        .line_idx   (line_idx),
        .sched_busy (sched_busy),
        .err_timeout(err_timeout)
    );

    always #10 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic typ, input int l);
        cmd_t e;
        e.typ  = typ;
        e.addr = typ ? 17'd0 : 17'(l * 320);
        e.len  = typ ? 9'd64 : 9'd320;
        e.fs   = !typ && (l == 0);
        exp_q.push_back(e);
    endtask

    // Wait (bounded) for cmd_valid and compare its fields with the scoreboard head.
    task automatic wait_cmd(output int lat);
        cmd_t e;
        lat = 0;
        while (!cmd_valid && lat < 200) begin
            tick();
            lat++;
        end
        if (!cmd_valid) begin
            check_eq("cmd_wait_timeout", 0, 1);
            exp_fs = 1'b0;
        end else if (exp_q.size() == 0) begin
            check_eq("sb_empty", 0, 1);
            exp_fs = 1'b0;
        end else begin
            e = exp_q.pop_front();
            check_eq("cmd_type", 32'(cmd_type), 32'(e.typ));
            check_eq("cmd_addr", 32'(cmd_addr), 32'(e.addr));
            check_eq("cmd_len", 32'(cmd_len), 32'(e.len));
            exp_fs = e.fs;
        end
    endtask

    task automatic accept();
        cmd_ready = 1'b1;
        tick();
        check_eq("valid_clr", 32'(cmd_valid), 0);
        check_eq("frame_start", 32'(frame_start), 32'(exp_fs));
    endtask

    task automatic finish_pkt(input logic done, input logic abort);
        tx_done  = done;
        tx_abort = abort;
        tick();
        tx_done  = 1'b0;
        tx_abort = 1'b0;
    endtask

    task automatic video_pkt(input int l);
        int lat;
        push_exp(1'b0, l);
        wait_cmd(lat);
        accept();
    endtask

    task automatic check_reset_outs();
        check_eq("rst_valid", 32'(cmd_valid), 0);
        check_eq("rst_type", 32'(cmd_type), 0);
        check_eq("rst_addr", 32'(cmd_addr), 0);
        check_eq("rst_len", 32'(cmd_len), 0);
        check_eq("rst_fs", 32'(frame_start), 0);
        check_eq("rst_line", 32'(line_idx), 0);
        check_eq("rst_busy", 32'(sched_busy), 0);
        check_eq("rst_err", 32'(err_timeout), 0);
    endtask

    initial begin
        int lat;
        rst         = 1'b1;
        enable      = 1'b0;
        audio_level = 10'd0;
        cmd_ready   = 1'b1;
        tx_done     = 1'b0;
        tx_abort    = 1'b0;
        repeat (3) tick();
        check_reset_outs();
        rst = 1'b0;
        tick();
        check_eq("idle_busy", 32'(sched_busy), 0);

        // First video line after enable, then the IFG latency.
        enable = 1'b1;
        push_exp(1'b0, 0);
        wait_cmd(lat);
        check_eq("first_lat", lat, 2);
        check_eq("busy_run", 32'(sched_busy), 1);
        accept();
        finish_pkt(1'b1, 1'b0);
        push_exp(1'b0, 1);
        wait_cmd(lat);
        check_eq("ifg_lat", lat, 49);
        accept();

        // Audio / video alternation while the FIFO holds a chunk.
        audio_level = 10'd64;
        finish_pkt(1'b1, 1'b0);
        push_exp(1'b1, 0);
        wait_cmd(lat);
        accept();
        finish_pkt(1'b1, 1'b0);
        video_pkt(2);
        finish_pkt(1'b1, 1'b0);
        push_exp(1'b1, 0);
        wait_cmd(lat);
        accept();
        audio_level = 10'd0;

        // Rest of the frame, then wrap to line 0.
        for (int l = 3; l < 240; l++) begin
            finish_pkt(1'b1, 1'b0);
            video_pkt(l);
        end
        check_eq("addr_line239", 32'(cmd_addr), 76480);
        finish_pkt(1'b1, 1'b0);
        video_pkt(0);
        check_eq("wrap_line", 32'(line_idx), 0);

        // Abort resends the line; done beats a simultaneous abort.
        for (int l = 1; l <= 5; l++) begin
            finish_pkt(1'b1, 1'b0);
            video_pkt(l);
        end
        finish_pkt(1'b0, 1'b1);
        video_pkt(5);
        check_eq("abort_line", 32'(line_idx), 5);
        finish_pkt(1'b1, 1'b1);
        video_pkt(6);
        check_eq("both_addr", 32'(cmd_addr), 1920);

        // Back-pressure: command held stable; a stray tx_done is ignored.
        cmd_ready = 1'b0;
        finish_pkt(1'b1, 1'b0);
        push_exp(1'b0, 7);
        wait_cmd(lat);
        for (int i = 0; i < 10; i++) begin
            tx_done = (i == 3);
            tick();
            tx_done = 1'b0;
            check_eq("hold_valid", 32'(cmd_valid), 1);
            check_eq("hold_addr", 32'(cmd_addr), 2240);
            check_eq("hold_len", 32'(cmd_len), 320);
        end
        accept();
        check_eq("stray_done_line", 32'(line_idx), 7);

        // Disable mid-packet: pending audio still goes out, then IDLE.
        enable      = 1'b0;
        audio_level = 10'd64;
        finish_pkt(1'b1, 1'b0);
        push_exp(1'b1, 0);
        wait_cmd(lat);
        accept();
        audio_level = 10'd0;
        finish_pkt(1'b1, 1'b0);
        repeat (60) tick();
        check_eq("idle_busy2", 32'(sched_busy), 0);
        check_eq("idle_valid", 32'(cmd_valid), 0);
        check_eq("idle_line", 32'(line_idx), 8);

        // Reset in the middle of a packet.
        enable = 1'b1;
        video_pkt(8);
        rst = 1'b1;
        tick();
        check_reset_outs();
        rst = 1'b0;
        video_pkt(0);
        finish_pkt(1'b1, 1'b0);
        repeat (2) tick();
        check_eq("sb_left", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
